button_event_queue: RTL and testbench
=====================================

BUTTON_EVENT_QUEUE -- requirements
Module: button_event_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries; power of two, 2..16.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 300000000, clk cycles of player inactivity before timeout (3 s at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock, 100 MHz; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pb_pulse  input  5  one-cycle debounced press pulses, bit i = button i.
REQ-006 SHALL have port clear  input  1  flush FIFO and clear overflow.
REQ-007 SHALL have port arm  input  1  start or restart the inactivity window.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts the head event.
REQ-009 SHALL have port evt_valid  output  1  FIFO not empty.
REQ-010 SHALL have port evt_code  output  3  head event button index, 0..4.
REQ-011 SHALL have port fill  output  5  current entry count, 0..DEPTH.
REQ-012 SHALL have port overflow  output  1  sticky; an event was dropped.
REQ-013 SHALL have port multi_press  output  1  one-cycle pulse; rejected multi-bit input.
REQ-014 SHALL have port timeout  output  1  one-cycle pulse; inactivity window expired.

Function
REQ-015 SHALL treat a pb_pulse cycle with exactly one bit set as a push request carrying that bit index as code.
REQ-016 SHALL ignore pb_pulse == 0.
REQ-017 SHALL neither push nor drop on a multi-bit pb_pulse, and SHALL assert multi_press in the next cycle for one cycle.
REQ-018 SHALL be first-word-fall-through: evt_valid = (fill != 0), evt_code = head entry, registered.
REQ-019 SHALL pop when evt_valid && evt_ready in the same cycle.
REQ-020 SHALL make a push in cycle N visible on evt_valid/evt_code/fill in cycle N+1.
REQ-021 SHALL perform both push and pop when requested together, full or not; fill stays unchanged.
REQ-022 SHALL drop a push when full with no pop, and set overflow from the next cycle until rst or clear.
REQ-023 SHALL ignore a pop request when empty; evt_code is don't-care when evt_valid = 0.
REQ-024 SHALL wrap read and write pointers modulo DEPTH.
REQ-025 SHALL give clear priority over same-cycle push and pop: next cycle fill = 0, overflow = 0, the pb_pulse event is discarded.
REQ-026 SHALL run a timeout FSM with states IDLE, WAIT.
REQ-027 SHALL transition IDLE -> WAIT on arm, counter = 0.
REQ-028 SHALL restart the counter at 0 on arm while in WAIT.
REQ-029 SHALL reset the counter to 0 on any accepted push in WAIT.
REQ-030 SHALL, in WAIT, pulse timeout one cycle when the counter reaches TIMEOUT_CYCLES-1, then return to IDLE.
REQ-031 SHALL give arm priority over expiry in the same cycle: no timeout pulse, counter restarts.
REQ-032 SHALL hold the counter at 0 and keep timeout = 0 in IDLE.

Reset
REQ-033 SHALL, on rst, next cycle: fill = 0, evt_valid = 0, evt_code = 0, overflow = 0, multi_press = 0, timeout = 0, FSM = IDLE, counter = 0, pointers = 0.
REQ-034 SHALL discard all stored events and any in-progress timeout window on rst mid-operation, with rst priority over every other input.

Configuration
REQ-035 SHALL, with macro INPUT_TIMEOUT_EN defined, implement REQ-026..REQ-032.
REQ-036 SHALL, without INPUT_TIMEOUT_EN, omit the timeout FSM and counter, tie timeout to 0, and ignore arm; all FIFO behaviour is unchanged.

Verification
REQ-037 SHALL cover: pb_pulse = 5'b00100 one cycle, evt_ready = 0 -> next cycle evt_valid = 1, evt_code = 2, fill = 1.
REQ-038 SHALL cover: pb_pulse = 5'b00101 -> multi_press pulses once, fill unchanged, overflow = 0.
REQ-039 SHALL cover: DEPTH = 8; nine single-bit pushes with evt_ready = 0 -> fill = 8, overflow = 1, popped codes equal the first eight pushed in order.
REQ-040 SHALL cover: full FIFO, push code 4 with evt_ready = 1 -> fill stays 8, the last entry is 4, overflow = 0.
REQ-041 SHALL cover: INPUT_TIMEOUT_EN, TIMEOUT_CYCLES = 10, arm then no input -> timeout high exactly one cycle, 10 cycles after arm; a push at cycle 5 delays expiry to cycle 15.
REQ-042 SHALL cover: rst asserted with fill = 3 and FSM in WAIT -> next cycle all outputs 0, and no timeout afterwards without a new arm.

Source files
------------

// File: rtl/button_event_queue.sv
// Button press event FIFO with multi-press rejection, sticky overflow and an
// optional player-inactivity timeout (enabled by defining INPUT_TIMEOUT_EN).
module button_event_queue #(
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 300000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] pb_pulse,
  input  logic       clear,
  input  logic       arm,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic [4:0] fill,
  output logic       overflow,
  output logic       multi_press,
  output logic       timeout
);

  localparam int unsigned NB = 5;
  localparam int unsigned CW = 3;
  localparam int unsigned FW = 5;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic [2:0]    ones_c;
  logic [CW-1:0] code_c;
  logic          push_req_c;
  logic          multi_c;
  logic          pop_c;
  logic          full_c;
  logic          push_c;
  logic          drop_c;
  logic [AW-1:0] rd_nxt_c;
  logic [FW-1:0] fill_nxt_c;
  logic [FW-1:0] fill_after_pop_c;
  logic [CW-1:0] head_nxt_c;

  // Decode the pulse vector: bit count and index of the set bit
  always_comb begin
    ones_c = '0;
    code_c = '0;
    for (int i = 0; i < NB; i++) begin
      if (pb_pulse[i]) begin
        code_c = CW'(i);
        ones_c = ones_c + 3'd1;
      end
    end
  end

  assign push_req_c = (ones_c == 3'd1);
  assign multi_c    = (ones_c > 3'd1);

  // Clear discards the same-cycle push and pop entirely
  assign pop_c      = evt_valid && evt_ready && !clear;
  assign full_c     = (fill == FW'(DEPTH));
  assign push_c     = push_req_c && !clear && (!full_c || pop_c);
  assign drop_c     = push_req_c && !clear && full_c && !pop_c;

  assign rd_nxt_c         = rd_ptr + AW'(pop_c);
  assign fill_after_pop_c = fill - FW'(pop_c);
  assign fill_nxt_c       = fill_after_pop_c + FW'(push_c);

  // Next head: the incoming code when it lands in an otherwise empty queue
  always_comb begin
    head_nxt_c = '0;
    if (fill_nxt_c != '0) begin
      if (fill_after_pop_c == '0) begin
        head_nxt_c = code_c;
      end else begin
        head_nxt_c = mem[rd_nxt_c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem[wr_ptr] <= code_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      fill        <= '0;
      evt_valid   <= 1'b0;
      evt_code    <= '0;
      overflow    <= 1'b0;
      multi_press <= 1'b0;
    end else begin
      multi_press <= multi_c;
      if (clear) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        fill      <= '0;
        evt_valid <= 1'b0;
        evt_code  <= '0;
        overflow  <= 1'b0;
      end else begin
        if (push_c) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        rd_ptr    <= rd_nxt_c;
        fill      <= fill_nxt_c;
        evt_valid <= (fill_nxt_c != '0);
        evt_code  <= head_nxt_c;
        if (drop_c) begin
          overflow <= 1'b1;
        end
      end
    end
  end

`ifdef INPUT_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } to_state_t;

  to_state_t     to_state;
  logic [TW-1:0] to_cnt;

  // Inactivity window: arm and accepted pushes restart it, arm beats expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      to_state <= S_IDLE;
      to_cnt   <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (to_state)
        S_IDLE: begin
          to_cnt <= '0;
          if (arm) begin
            to_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (arm || push_c) begin
            to_cnt <= '0;
          end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout  <= 1'b1;
            to_state <= S_IDLE;
            to_cnt   <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
      endcase
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^{arm, 32'(TIMEOUT_CYCLES)};
`endif

endmodule

// File: tb/tb_button_event_queue.sv
// Directed self-checking bench for button_event_queue (DEPTH 8, timeout 10).
module tb_button_event_queue;

`ifdef INPUT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] pb_pulse;
  logic       clear;
  logic       arm;
  logic       evt_ready;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [4:0] fill;
  logic       overflow;
  logic       multi_press;
  logic       timeout;

  int vectors     = 0;
  int miscompares = 0;

  button_event_queue #(
    .DEPTH          (8),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pb_pulse    (pb_pulse),
    .clear       (clear),
    .arm         (arm),
    .evt_ready   (evt_ready),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .fill        (fill),
    .overflow    (overflow),
    .multi_press (multi_press),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int c);
    pb_pulse = 5'(1 << c);
    tick();
    pb_pulse = '0;
  endtask

  initial begin
    rst = 1'b1; pb_pulse = '0; clear = 1'b0; arm = 1'b0; evt_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_code", 32'(evt_code), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_multi", 32'(multi_press), 0);
    chk("rst_timeout", 32'(timeout), 0);

    // Single push becomes visible the next cycle
    push(2);
    chk("push_valid", 32'(evt_valid), 1);
    chk("push_code", 32'(evt_code), 2);
    chk("push_fill", 32'(fill), 1);

    // Multi-bit pulse rejected
    pb_pulse = 5'b00101;
    tick();
    pb_pulse = '0;
    chk("multi_pulse", 32'(multi_press), 1);
    chk("multi_fill", 32'(fill), 1);
    chk("multi_ovf", 32'(overflow), 0);
    tick();
    chk("multi_once", 32'(multi_press), 0);

    // Pop, then pop on empty
    evt_ready = 1'b1;
    tick();
    chk("pop_fill", 32'(fill), 0);
    chk("pop_valid", 32'(evt_valid), 0);
    tick();
    chk("pop_empty_fill", 32'(fill), 0);
    evt_ready = 1'b0;

    // Simultaneous push and pop with one entry
    push(3);
    pb_pulse = 5'b00010; evt_ready = 1'b1;
    tick();
    pb_pulse = '0; evt_ready = 1'b0;
    chk("pp_fill", 32'(fill), 1);
    chk("pp_code", 32'(evt_code), 1);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("pp_drain", 32'(fill), 0);

    // Nine pushes into DEPTH 8: last is dropped
    for (int i = 0; i < 9; i++) begin
      push(i % 5);
      if (i == 7) begin
        chk("full_fill", 32'(fill), 8);
        chk("full_ovf", 32'(overflow), 0);
      end
    end
    chk("ovf_fill", 32'(fill), 8);
    chk("ovf_flag", 32'(overflow), 1);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_order", 32'(evt_code), 32'(i % 5));
      tick();
    end
    evt_ready = 1'b0;
    chk("ovf_drained", 32'(fill), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_ovf", 32'(overflow), 0);

    // Full FIFO with push and pop together
    for (int i = 0; i < 8; i++) push((i + 1) % 5);
    chk("refill_fill", 32'(fill), 8);
    pb_pulse = 5'b10000; evt_ready = 1'b1;
    tick();
    pb_pulse = '0; evt_ready = 1'b0;
    chk("fullpp_fill", 32'(fill), 8);
    chk("fullpp_ovf", 32'(overflow), 0);
    chk("fullpp_head", 32'(evt_code), 2);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("fullpp_order", 32'(evt_code), 32'((i + 2) % 5));
      tick();
    end
    evt_ready = 1'b0;
    chk("fullpp_drained", 32'(evt_valid), 0);

    // Clear beats same-cycle push and pop
    push(0);
    push(1);
    for (int i = 0; i < 8; i++) push(4);
    chk("pre_clear_ovf", 32'(overflow), 1);
    clear = 1'b1; pb_pulse = 5'b00001; evt_ready = 1'b1;
    tick();
    clear = 1'b0; pb_pulse = '0; evt_ready = 1'b0;
    chk("clear_fill", 32'(fill), 0);
    chk("clear_valid", 32'(evt_valid), 0);
    chk("clear_ovf2", 32'(overflow), 0);

    // Timeout after arm with no input
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk("to_plain", 32'(timeout), 32'(TO_EN && k == 10));
    end

    // Push at cycle 5 delays expiry to cycle 15
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 5) pb_pulse = 5'b00001;
      tick();
      pb_pulse = '0;
      chk("to_push", 32'(timeout), 32'(TO_EN && k == 15));
    end

    // Re-arm on the expiry cycle wins
    arm = 1'b1;
    tick();
    arm = 1'b0;
    for (int k = 1; k <= 25; k++) begin
      if (k == 10) arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("to_rearm", 32'(timeout), 32'(TO_EN && k == 20));
    end

    // Reset mid-operation with entries stored and a window open
    clear = 1'b1;
    tick();
    clear = 1'b0;
    push(0);
    push(1);
    push(2);
    chk("mid_fill", 32'(fill), 3);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    tick();
    tick();
    rst = 1'b1; pb_pulse = 5'b00011;
    tick();
    rst = 1'b0; pb_pulse = '0;
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_code", 32'(evt_code), 0);
    chk("mid_rst_fill", 32'(fill), 0);
    chk("mid_rst_ovf", 32'(overflow), 0);
    chk("mid_rst_multi", 32'(multi_press), 0);
    chk("mid_rst_timeout", 32'(timeout), 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("post_rst_timeout", 32'(timeout), 0);
    end
    chk("post_rst_fill", 32'(fill), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
